weak_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the core's simple req/ack memory bus. Master 0 is the instruction-fetch port and master 1 is the load/store data port. They share a single memory slave.
- Latches one grant per transaction and muxes the winner's address, write data and write enable to the slave.
- Routes the slave's ack and read data back to the winner only.
- Bounds slave latency with a timeout counter.
- Sits between the core's bus ports and the memory/peripheral interconnect.

---
 rtl/weak_bus_pkg.sv | 32 +++
 rtl/weak_arb_timer.sv | 42 ++++
 rtl/weak_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_weak_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weak_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter: state encodings,
// master indices, the timeout error word and the arbitration helpers.
package weak_bus_pkg;

    // Read data handed back to a master whose transaction timed out.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Master indices; also the encoding used for err_id and last_grant.
    localparam logic M_FETCH = 1'b0;
    localparam logic M_DATA  = 1'b1;

    // Registered one-hot arbiter states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_GNT0 = 3'b010,
        ST_GNT1 = 3'b100
    } state_t;

    // Fixed priority: the data port always beats the fetch port.
    function automatic logic pick_fixed(input logic req1);
        return req1 ? M_DATA : M_FETCH;
    endfunction

    // Round-robin: on a tie the master that did not complete last wins.
    function automatic logic pick_rr(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1 ? M_DATA : M_FETCH;
    endfunction

endpackage

// File: rtl/weak_arb_timer.sv
// Grant-latency counter: cleared while no grant is held, counts stalled grant
// cycles and flags the cycle in which the count reaches TIMEOUT-1.
// TIMEOUT=0 disables expiry entirely.
module weak_arb_timer
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));
    localparam bit   TMO_EN         = (TIMEOUT != 0);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);

    // Counter saturates at the last value; the arbiter leaves the grant there anyway.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_last) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Expiry is only meaningful when a finite timeout is configured.
    always_comb begin
        o_expired = 1'b0;
        if (TMO_EN) begin
            o_expired = w_at_last;
        end
    end

endmodule

// File: rtl/weak_bus_arbiter.sv
// Two-master (fetch / data) to one-slave req/ack bus arbiter.
// One grant per transaction, 1-cycle arbitration in IDLE, ack/rdata routed to
// the winner only, master-drop and slave-timeout reported on err/err_id.
// Optional build macro WEAK_ARB_RR_EN selects round-robin arbitration with a
// last_grant register; otherwise m1 has fixed priority over m0.
module weak_bus_arbiter
    import weak_bus_pkg::*;
#(
    parameter int unsigned     AW       = 32,
    parameter int unsigned     DW       = 32,
    parameter int unsigned     TIMEOUT  = 16,
    parameter logic [DW-1:0]   ERR_DATA = DW'(ERR_DATA_DEFAULT)
)
(
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_wr,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_wr,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,

    output logic          s_req,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic          s_wr,
    input  logic          s_ack,
    input  logic [DW-1:0] s_rdata,

    output logic          err,
    output logic          err_id
);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_err_id;

    logic          w_in_gnt;
    logic          w_gnt_id;
    logic          w_sel_req;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_sel_wr;
    logic          w_expired;
    logic          w_drop;
    logic          w_done;
    logic          w_tmo;
    logic          w_finish;
    logic          w_err;
    logic [DW-1:0] w_ack_data;
    logic          w_pick;

    // Grant decode and mux of the granted master's request onto the slave side.
    assign w_in_gnt    = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    assign w_gnt_id    = (r_state == ST_GNT1) ? M_DATA : M_FETCH;
    assign w_sel_req   = (w_gnt_id == M_DATA) ? m1_req   : m0_req;
    assign w_sel_addr  = (w_gnt_id == M_DATA) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_gnt_id == M_DATA) ? m1_wdata : m0_wdata;
    assign w_sel_wr    = (w_gnt_id == M_DATA) ? m1_wr    : m0_wr;

    // Grant-state events: a dropped request wins over ack, and ack wins over timeout.
    assign w_drop     = w_in_gnt & ~w_sel_req;
    assign w_done     = w_in_gnt &  w_sel_req & s_ack;
    assign w_tmo      = w_in_gnt &  w_sel_req & ~s_ack & w_expired;
    assign w_finish   = w_done | w_tmo;
    assign w_err      = w_drop | w_tmo;
    assign w_ack_data = w_done ? s_rdata : ERR_DATA;

`ifdef WEAK_ARB_RR_EN
    logic r_last_grant;

    // Remember who completed last so a tie goes to the other master.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= M_DATA;
        end else if (w_finish) begin
            r_last_grant <= w_gnt_id;
        end
    end

    assign w_pick = pick_rr(m0_req, m1_req, r_last_grant);
`else
    assign w_pick = pick_fixed(m1_req);
`endif

    // Stalled-grant cycle counter; held clear whenever no grant is active.
    weak_arb_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (~w_in_gnt),
        .i_en      (w_in_gnt & ~s_ack),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Master index of the most recent error, held between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_id <= M_FETCH;
        end else if (w_err) begin
            r_err_id <= w_gnt_id;
        end
    end

    // Next-state: arbitrate in IDLE, return to IDLE on completion, drop or timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_next_state = (w_pick == M_DATA) ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (w_drop || w_finish) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs: slave drive and ack routing for the granted master; all zero in reset.
    always_comb begin
        s_req    = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wr     = 1'b0;
        m0_ack   = 1'b0;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_rdata = '0;
        err      = 1'b0;
        err_id   = 1'b0;
        if (!rst) begin
            if (w_in_gnt) begin
                s_req   = w_sel_req & ~w_tmo;
                s_addr  = w_sel_addr;
                s_wdata = w_sel_wdata;
                s_wr    = w_sel_wr;
            end
            if (w_finish) begin
                if (w_gnt_id == M_DATA) begin
                    m1_ack   = 1'b1;
                    m1_rdata = w_ack_data;
                end else begin
                    m0_ack   = 1'b1;
                    m0_rdata = w_ack_data;
                end
            end
            err    = w_err;
            err_id = w_err ? w_gnt_id : r_err_id;
        end
    end

endmodule

// File: tb/tb_weak_bus_arbiter.sv
// Directed bench for weak_bus_arbiter (fixed-priority build, TIMEOUT=8).
module tb_weak_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_wr;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_wr;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wr;
    logic        s_ack;
    logic [31:0] s_rdata;
    logic        err;
    logic        err_id;

    int total = 0;
    int bad   = 0;

    weak_bus_arbiter #(
        .AW       (32),
        .DW       (32),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wr    (m0_wr),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wr    (m1_wr),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wr     (s_wr),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata),
        .err      (err),
        .err_id   (err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".s_req"},    32'(s_req),    32'h0);
        chk({tag, ".s_addr"},   s_addr,        32'h0);
        chk({tag, ".s_wdata"},  s_wdata,       32'h0);
        chk({tag, ".s_wr"},     32'(s_wr),     32'h0);
        chk({tag, ".m0_ack"},   32'(m0_ack),   32'h0);
        chk({tag, ".m0_rdata"}, m0_rdata,      32'h0);
        chk({tag, ".m1_ack"},   32'(m1_ack),   32'h0);
        chk({tag, ".m1_rdata"}, m1_rdata,      32'h0);
        chk({tag, ".err"},      32'(err),      32'h0);
        chk({tag, ".err_id"},   32'(err_id),   32'h0);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wr = 1'b0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wr = 1'b0;
        s_ack = 1'b0;  s_rdata = '0;

        // Reset
        cyc; #1;
        chk_all_zero("reset");

        // Single read by m0, slave acks two cycles after s_req rises
        cyc; rst = 1'b0; m0_req = 1'b1; m0_addr = 32'h10; #1;
        chk("rd.idle_sreq", 32'(s_req), 32'h0);
        cyc; #1;
        chk("rd.g1_sreq",  32'(s_req),  32'h1);
        chk("rd.g1_saddr", s_addr,      32'h10);
        chk("rd.g1_ack",   32'(m0_ack), 32'h0);
        cyc; #1;
        chk("rd.g2_ack",   32'(m0_ack), 32'h0);
        cyc; s_ack = 1'b1; s_rdata = 32'h12345678; #1;
        chk("rd.ack",      32'(m0_ack), 32'h1);
        chk("rd.rdata",    m0_rdata,    32'h12345678);
        chk("rd.m1_ack",   32'(m1_ack), 32'h0);
        chk("rd.m1_rdata", m1_rdata,    32'h0);
        chk("rd.err",      32'(err),    32'h0);
        cyc; s_ack = 1'b0; s_rdata = '0; m0_req = 1'b0; #1;
        chk("rd.post_sreq",  32'(s_req),  32'h0);
        chk("rd.post_ack",   32'(m0_ack), 32'h0);
        chk("rd.post_rdata", m0_rdata,    32'h0);

        // Write by m1 while m0 idle
        cyc; m1_req = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hCAFE; m1_wr = 1'b1; #1;
        chk("wr.idle_sreq", 32'(s_req), 32'h0);
        cyc; #1;
        chk("wr.sreq",   32'(s_req), 32'h1);
        chk("wr.swr",    32'(s_wr),  32'h1);
        chk("wr.swdata", s_wdata,    32'hCAFE);
        chk("wr.saddr",  s_addr,     32'h100);
        chk("wr.pre_ack", 32'(m1_ack), 32'h0);
        cyc; s_ack = 1'b1; #1;
        chk("wr.ack",    32'(m1_ack), 32'h1);
        chk("wr.m0_ack", 32'(m0_ack), 32'h0);
        cyc; s_ack = 1'b0; m1_req = 1'b0; m1_wr = 1'b0; m1_wdata = '0; #1;
        chk("wr.post_swr",  32'(s_wr),  32'h0);
        chk("wr.post_sreq", 32'(s_req), 32'h0);

        // Contention: m1 first, one IDLE cycle, then m0
        cyc; m0_req = 1'b1; m0_addr = 32'h20; m1_req = 1'b1; m1_addr = 32'h30; #1;
        chk("ct.idle_sreq", 32'(s_req), 32'h0);
        cyc; #1;
        chk("ct.first_addr", s_addr,     32'h30);
        chk("ct.first_sreq", 32'(s_req), 32'h1);
        cyc; s_ack = 1'b1; s_rdata = 32'h1111; #1;
        chk("ct.m1_ack",   32'(m1_ack), 32'h1);
        chk("ct.m1_rdata", m1_rdata,    32'h1111);
        chk("ct.m0_ack0",  32'(m0_ack), 32'h0);
        chk("ct.m0_rdata0", m0_rdata,   32'h0);
        cyc; s_ack = 1'b0; s_rdata = '0; m1_req = 1'b0; #1;
        chk("ct.gap_sreq", 32'(s_req),  32'h0);
        chk("ct.gap_ack",  32'(m0_ack), 32'h0);
        cyc; #1;
        chk("ct.second_sreq", 32'(s_req), 32'h1);
        chk("ct.second_addr", s_addr,     32'h20);
        cyc; s_ack = 1'b1; s_rdata = 32'h2222; #1;
        chk("ct.m0_ack",   32'(m0_ack), 32'h1);
        chk("ct.m0_rdata", m0_rdata,    32'h2222);
        chk("ct.m1_ack0",  32'(m1_ack), 32'h0);
        cyc; s_ack = 1'b0; s_rdata = '0; m0_req = 1'b0; #1;

        // Timeout: m0 requests, slave silent; expiry in the 8th GNT0 cycle
        cyc; m0_req = 1'b1; m0_addr = 32'h40; #1;
        chk("to.idle_sreq", 32'(s_req), 32'h0);
        for (int i = 1; i <= 7; i++) begin
            cyc; #1;
            chk($sformatf("to.wait%0d_ack", i),  32'(m0_ack), 32'h0);
            chk($sformatf("to.wait%0d_err", i),  32'(err),    32'h0);
            chk($sformatf("to.wait%0d_sreq", i), 32'(s_req),  32'h1);
        end
        cyc; #1;
        chk("to.ack",    32'(m0_ack), 32'h1);
        chk("to.rdata",  m0_rdata,    32'hDEADBEEF);
        chk("to.err",    32'(err),    32'h1);
        chk("to.err_id", 32'(err_id), 32'h0);
        chk("to.sreq",   32'(s_req),  32'h0);
        cyc; m0_req = 1'b0; #1;
        chk("to.post_err",  32'(err),    32'h0);
        chk("to.post_ack",  32'(m0_ack), 32'h0);
        chk("to.post_sreq", 32'(s_req),  32'h0);

        // Ack arriving in the expiry cycle is a normal completion
        cyc; m1_req = 1'b1; m1_addr = 32'h44; #1;
        for (int i = 1; i <= 7; i++) begin
            cyc; #1;
            chk($sformatf("tb.wait%0d_ack", i), 32'(m1_ack), 32'h0);
            chk($sformatf("tb.wait%0d_err", i), 32'(err),    32'h0);
        end
        cyc; s_ack = 1'b1; s_rdata = 32'h5555; #1;
        chk("tb.ack",   32'(m1_ack), 32'h1);
        chk("tb.rdata", m1_rdata,    32'h5555);
        chk("tb.err",   32'(err),    32'h0);
        cyc; s_ack = 1'b0; s_rdata = '0; m1_req = 1'b0; #1;

        // Stray s_ack in IDLE is ignored
        cyc; s_ack = 1'b1; s_rdata = 32'h9999; #1;
        chk("stray.m0_ack",   32'(m0_ack), 32'h0);
        chk("stray.m1_ack",   32'(m1_ack), 32'h0);
        chk("stray.m0_rdata", m0_rdata,    32'h0);
        chk("stray.m1_rdata", m1_rdata,    32'h0);
        chk("stray.err",      32'(err),    32'h0);

        // m0 drops its request mid-grant
        cyc; s_ack = 1'b0; s_rdata = '0; m0_req = 1'b1; m0_addr = 32'h60; #1;
        cyc; #1;
        chk("drop0.gnt_sreq", 32'(s_req), 32'h1);
        cyc; m0_req = 1'b0; #1;
        chk("drop0.err",    32'(err),    32'h1);
        chk("drop0.err_id", 32'(err_id), 32'h0);
        chk("drop0.ack",    32'(m0_ack), 32'h0);
        chk("drop0.sreq",   32'(s_req),  32'h0);
        cyc; m1_req = 1'b1; m1_addr = 32'h70; #1;
        chk("drop0.idle_err",  32'(err),   32'h0);
        chk("drop0.idle_sreq", 32'(s_req), 32'h0);
        cyc; #1;
        chk("drop1.gnt_sreq", 32'(s_req), 32'h1);
        chk("drop1.gnt_addr", s_addr,     32'h70);
        cyc; m1_req = 1'b0; #1;
        chk("drop1.err",    32'(err),    32'h1);
        chk("drop1.err_id", 32'(err_id), 32'h1);
        chk("drop1.ack",    32'(m1_ack), 32'h0);
        cyc; #1;
        chk("drop1.idle_err",  32'(err),    32'h0);
        chk("drop1.hold_id",   32'(err_id), 32'h1);
        chk("drop1.idle_sreq", 32'(s_req),  32'h0);

        // Reset while m1 holds the grant with ack pending
        cyc; m1_req = 1'b1; m1_addr = 32'h50; #1;
        cyc; #1;
        chk("rstm.gnt_sreq", 32'(s_req), 32'h1);
        cyc; rst = 1'b1; #1;
        chk_all_zero("rstm.in_rst");
        cyc; rst = 1'b0; m1_req = 1'b0; #1;
        chk_all_zero("rstm.after");
        cyc; s_ack = 1'b1; s_rdata = 32'hABCD; #1;
        chk("rstm.late_ack",   32'(m1_ack), 32'h0);
        chk("rstm.late_rdata", m1_rdata,    32'h0);
        chk("rstm.late_sreq",  32'(s_req),  32'h0);
        chk("rstm.late_errid", 32'(err_id), 32'h0);
        cyc; s_ack = 1'b0; s_rdata = '0; #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
